// File: rtl/time_set_ctrl_if.sv
// Button/tick pulses into the time-setting controller and the registered time/edit display state out of it.
interface time_set_ctrl_if;
  logic       tick_1Hz;
  logic       mode_short;
  logic       mode_long;
  logic       inc_short;
  logic       inc_long;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] field;
  logic       blink;

  modport master (
    output tick_1Hz, mode_short, mode_long, inc_short, inc_long,
    input  hours, minutes, seconds, field, blink
  );

  modport slave (
    input  tick_1Hz, mode_short, mode_long, inc_short, inc_long,
    output hours, minutes, seconds, field, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Clock time-of-day keeper with a two-button set mode: field selection, increments,
// idle timeout back to RUN, and a blink enable for the field being edited.
module time_set_ctrl #(
  parameter int unsigned BLINK_HALF = 5000,
  parameter int unsigned TIMEOUT_S  = 30
) (
  input  logic           clk_10000Hz,
  input  logic           rst,
  time_set_ctrl_if.slave bus
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SET_HR  = 2'd1;
  localparam logic [1:0] SET_MIN = 2'd2;
  localparam logic [1:0] SET_SEC = 2'd3;

  localparam int unsigned IW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [1:0]    state_q, state_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          blink_q, blink_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          entry, refresh;

  always_comb begin
    state_d = state_q;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    idle_d  = idle_q;
    bcnt_d  = bcnt_q;
    entry   = 1'b0;
    refresh = 1'b0;

    if (state_q == RUN && bus.tick_1Hz) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d   = '0;
          hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (bus.mode_long) begin
      state_d = (state_q == RUN) ? SET_HR : RUN;
      entry   = 1'b1;
    end else if (bus.mode_short && state_q != RUN) begin
      // SET_SEC + 1 wraps to RUN in two bits
      state_d = state_q + 2'd1;
      entry   = 1'b1;
    end else if (state_q != RUN && (bus.inc_long || bus.inc_short)) begin
      refresh = 1'b1;
      case (state_q)
        SET_HR: begin
          if (bus.inc_long) hours_d = (hours_q >= 5'd14) ? hours_q - 5'd14 : hours_q + 5'd10;
          else              hours_d = (hours_q == 5'd23) ? '0 : hours_q + 5'd1;
        end
        SET_MIN: begin
          if (bus.inc_long) min_d = (min_q >= 6'd50) ? min_q - 6'd50 : min_q + 6'd10;
          else              min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        end
        default: begin
          if (bus.inc_long) sec_d = '0;
          else              sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
        end
      endcase
    end else if (state_q != RUN && bus.tick_1Hz) begin
      if (idle_q == IW'(TIMEOUT_S - 1)) begin
        state_d = RUN;
        entry   = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (entry || refresh || state_q == RUN) begin
      idle_d  = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_10000Hz) begin
    if (rst) begin
      state_q <= RUN;
      hours_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      blink_q <= 1'b1;
      idle_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hours_q <= hours_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blink_q <= blink_d;
      idle_q  <= idle_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bus.hours   = hours_q;
  assign bus.minutes = min_q;
  assign bus.seconds = sec_q;
  assign bus.field   = state_q;
  assign bus.blink   = blink_q;

endmodule
